fb_arbiter: RTL

Controller for a single-port frame buffer, shared between VGA scan-out reads and a drawing-engine write port. Display reads have absolute priority: one per pixel enable during active video. Writes fill every remaining clock slot through a req/ack handshake. Sits between the hsync/vsync timing blocks and the pixel outputs of the top level, replacing the image generator.

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_addr_gen.sv | 43 ++++
 rtl/fb_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer arbiter defaults, FSM states and RGB field positions
package fb_pkg;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int SHIFT = 2;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
  localparam int CH_W = 4;
  localparam int RED_LSB = 8;
  localparam int GRN_LSB = 4;
  localparam int BLU_LSB = 0;
  typedef enum logic [1:0] {IDLE, RD, WR} fb_state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: multiplier-free display address from replicated column/row counters
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H,
  parameter int SHIFT = fb_pkg::SHIFT,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              i_sclr,
  input  logic              i_slot,
  input  logic              i_haddr_en,
  input  logic              i_vaddr_en,
  output logic [ADDR_W-1:0] o_addr
);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(FB_W - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'((FB_H - 1) * FB_W);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
  logic [SHIFT-1:0] hsub, vsub;
  logic [ADDR_W-1:0] col, row_base;
  logic haddr_q, h_fall;
  assign h_fall = haddr_q & ~i_haddr_en;
  assign o_addr = row_base + col;
  // advance sub-pixel counters per slot, step rows on each line end
  always_ff @(posedge clk) begin
    haddr_q <= ~i_sclr & i_haddr_en;
    if (i_sclr || !i_vaddr_en) begin
      hsub <= '0;
      vsub <= '0;
      col <= '0;
      row_base <= '0;
    end else if (h_fall) begin
      hsub <= '0;
      col <= '0;
      vsub <= vsub + 1'b1;
      if (&vsub && row_base < ROW_MAX) row_base <= row_base + ROW_STEP;
    end else if (i_slot) begin
      hsub <= hsub + 1'b1;
      if (&hsub && col < COL_MAX) col <= col + 1'b1;
    end
  end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: frame-buffer port arbiter, display reads over writes; FB_ARB_VBLANK_WR_EN limits writes to vblank
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H,
  parameter int SHIFT = fb_pkg::SHIFT,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              i_sclr,
  input  logic              i_px_clk,
  input  logic              i_haddr_en,
  input  logic              i_vaddr_en,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [CH_W-1:0]   o_vga_red,
  output logic [CH_W-1:0]   o_vga_green,
  output logic [CH_W-1:0]   o_vga_blue
);
  fb_state_t state;
  logic slot, wr_ok, wr_go, rd_q, blank_d1, blank_d2;
  logic [ADDR_W-1:0] disp_addr;
  assign slot = i_px_clk & i_haddr_en & i_vaddr_en;
`ifdef FB_ARB_VBLANK_WR_EN
  assign wr_ok = i_wr_req & ~o_wr_ack & ~i_vaddr_en;
`else
  assign wr_ok = i_wr_req & ~o_wr_ack;
`endif
  assign wr_go = ~slot & wr_ok;
  fb_addr_gen #(.FB_W(FB_W), .FB_H(FB_H), .SHIFT(SHIFT), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .i_sclr    (i_sclr),
    .i_slot    (slot),
    .i_haddr_en(i_haddr_en),
    .i_vaddr_en(i_vaddr_en),
    .o_addr    (disp_addr)
  );
  // choose next memory command: display read, else write, else idle
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state <= IDLE;
      o_mem_en <= 1'b0;
      o_mem_we <= 1'b0;
      o_wr_ack <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
    end else begin
      state <= slot ? RD : wr_go ? WR : IDLE;
      o_mem_en <= slot | wr_ok;
      o_mem_we <= wr_go;
      o_wr_ack <= wr_go;
      o_mem_addr <= slot ? disp_addr : wr_go ? i_wr_addr : '0;
      o_mem_wdata <= wr_go ? i_wr_data : '0;
    end
  end
  // register read data into the pixel, or black for enables outside active video
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      rd_q <= 1'b0;
      blank_d1 <= 1'b0;
      blank_d2 <= 1'b0;
      o_vga_red <= '0;
      o_vga_green <= '0;
      o_vga_blue <= '0;
    end else begin
      rd_q <= state == RD;
      blank_d1 <= i_px_clk & ~(i_haddr_en & i_vaddr_en);
      blank_d2 <= blank_d1;
      if (rd_q) begin
        o_vga_red <= i_mem_rdata[RED_LSB +: CH_W];
        o_vga_green <= i_mem_rdata[GRN_LSB +: CH_W];
        o_vga_blue <= i_mem_rdata[BLU_LSB +: CH_W];
      end else if (blank_d2) begin
        o_vga_red <= '0;
        o_vga_green <= '0;
        o_vga_blue <= '0;
      end
    end
  end
endmodule
